// File: rtl/fifo_burst_ctrl_if.sv
// Memory-bus write port: address, data and response channels.
// The scheduler drives it through master; the bus end uses slave.
interface fifo_burst_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_ADDR_W = 32
);

  logic [BUS_ADDR_W-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;

  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output aw_addr,
    output aw_len,
    output aw_valid,
    input  aw_ready,
    output w_data,
    output w_last,
    output w_valid,
    input  w_ready,
    input  b_valid,
    output b_ready
  );

  modport slave (
    input  aw_addr,
    input  aw_len,
    input  aw_valid,
    output aw_ready,
    input  w_data,
    input  w_last,
    input  w_valid,
    output w_ready,
    output b_valid,
    input  b_ready
  );

endinterface

// File: rtl/fifo_burst_ctrl.sv
// Drains a fall-through FIFO into fixed-length write bursts.
// Also sequences one frame of bursts from a base address.
module fifo_burst_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 32,
  parameter int BURST_LEN       = 16,
  parameter int BUS_ADDR_W      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int ADDR_WIDTH     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  frame_start_i,
  input  logic [BUS_ADDR_W-1:0] cfg_base_i,
  input  logic [15:0]           cfg_burst_num_i,

  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_counter_i,
  output logic                  fifo_rd_valid_o,

  fifo_burst_ctrl_if.master     bus,

  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH:0] CNT_BL =
    (ADDR_WIDTH + 1)'(BURST_LEN);
  localparam logic [7:0] LAST_BEAT =
    8'(BURST_LEN - 1);
  localparam logic [BUS_ADDR_W-1:0] ADDR_INC =
    BUS_ADDR_W'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [OW-1:0] OUT_MAX =
    OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [BUS_ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [15:0]           burst_left_q, burst_left_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  aw_valid_q, aw_valid_d;
  logic [BUS_ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic                  done_q, done_d;

  logic aw_hs;
  logic b_dec;
  logic w_valid;
  logic w_hs;
  logic start_ok;
  logic frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      next_addr_q  <= '0;
      burst_left_q <= '0;
      beat_cnt_q   <= '0;
      outst_q      <= '0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      next_addr_q  <= next_addr_d;
      burst_left_q <= burst_left_d;
      beat_cnt_q   <= beat_cnt_d;
      outst_q      <= outst_d;
      aw_valid_q   <= aw_valid_d;
      aw_addr_q    <= aw_addr_d;
      done_q       <= done_d;
    end
  end

  assign aw_hs = (state_q == ADDR) & aw_valid_q & bus.aw_ready;
  // A response with nothing outstanding is stray and dropped
  assign b_dec = bus.b_valid & (outst_q != '0);

  assign w_valid = (state_q == DATA) & ~fifo_empty_i;
  assign w_hs    = w_valid & bus.w_ready;

  assign frame_ok = frame_start_i & ~armed_q
                  & (cfg_burst_num_i != 16'd0);
  assign start_ok = armed_q
                  & (fifo_counter_i >= CNT_BL)
                  & (outst_q < OUT_MAX);

  always_comb begin
    outst_d = outst_q;
    unique case (1'b1)
      (aw_hs && !b_dec): outst_d = outst_q + OW'(1);
      (b_dec && !aw_hs): outst_d = outst_q - OW'(1);
      default:           outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    next_addr_d  = next_addr_q;
    burst_left_d = burst_left_q;
    beat_cnt_d   = beat_cnt_q;
    aw_valid_d   = aw_valid_q;
    aw_addr_d    = aw_addr_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_ok) begin
          next_addr_d  = cfg_base_i;
          burst_left_d = cfg_burst_num_i;
          armed_d      = 1'b1;
        end else if (start_ok) begin
          state_d    = ADDR;
          aw_valid_d = 1'b1;
          aw_addr_d  = next_addr_q;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          state_d     = DATA;
          aw_valid_d  = 1'b0;
          next_addr_d = next_addr_q + ADDR_INC;
          beat_cnt_d  = '0;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            burst_left_d = burst_left_q - 16'd1;
            if (burst_left_q == 16'd1) begin
              armed_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        aw_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.aw_addr  = aw_addr_q;
  assign bus.aw_len   = LAST_BEAT;
  assign bus.aw_valid = aw_valid_q;

  assign bus.w_data  = fifo_data_i;
  assign bus.w_valid = w_valid;
  assign bus.w_last  = w_valid & (beat_cnt_q == LAST_BEAT);
  assign bus.b_ready = 1'b1;

  assign fifo_rd_valid_o = w_hs;

  assign busy_o = armed_q
                | (state_q != IDLE)
                | (outst_q != '0);

  assign frame_done_o = done_q;

endmodule

// File: doc/fifo_burst_ctrl.md
# fifo_burst_ctrl

Burst write scheduler that drains a first-word-fall-through sync FIFO of captured pixel words into fixed-length write bursts on a memory-bus port. It watches FIFO occupancy, issues one address request per burst and streams exactly BURST_LEN data beats, popping the FIFO beat by beat. It sits between the DVP capture FIFO and the frame-buffer write master. It also sequences a frame: base address, burst count, wrap and a done pulse.

## Interface
- DATA_WIDTH, 32, FIFO word and bus data width; multiple of 8.
- FIFO_DEPTH, 32, depth of the attached FIFO.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), width of the FIFO pointer; derived, not configured.
- BURST_LEN, 16, beats per burst; 1..min(FIFO_DEPTH,256).
- BUS_ADDR_W, 32, bus address width.
- MAX_OUTSTANDING, 2, maximum address requests awaiting a response.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- frame_start_i  in  1  one-cycle pulse that arms a frame.
- cfg_base_i  in  BUS_ADDR_W  frame-buffer base address; sampled on an accepted frame_start_i.
- cfg_burst_num_i  in  16  bursts per frame; sampled on an accepted frame_start_i.
- fifo_data_i  in  DATA_WIDTH  FIFO head word (fall-through).
- fifo_empty_i  in  1  FIFO empty.
- fifo_counter_i  in  ADDR_WIDTH+1  FIFO occupancy.
- fifo_rd_valid_o  out  1  FIFO pop strobe.
- aw_addr_o  out  BUS_ADDR_W  burst start address.
- aw_len_o  out  8  burst length minus one; constant BURST_LEN-1.
- aw_valid_o / aw_ready_i  out/in  1  address handshake.
- w_data_o  out  DATA_WIDTH  write data; equals fifo_data_i.
- w_last_o  out  1  final beat of the burst.
- w_valid_o / w_ready_i  out/in  1  data handshake.
- b_valid_i  in  1  write response; b_ready_o is tied to 1.
- b_ready_o  out  1  constant 1.
- busy_o  out  1  frame armed or burst in flight.
- frame_done_o  out  1  one-cycle pulse when the frame completes.

## Operation
- FSM states: IDLE, ADDR, DATA.
- A frame_start_i is accepted only when state is IDLE, no frame is armed and cfg_burst_num_i != 0. On acceptance:
  - next_addr <= cfg_base_i, burst_left <= cfg_burst_num_i, armed <= 1.
  - frame_start_i is ignored in every other case.
- IDLE -> ADDR when armed & fifo_counter_i >= BURST_LEN & outstanding < MAX_OUTSTANDING.
  - On entry: aw_valid_o <= 1, aw_addr_o <= next_addr.
- ADDR:
  - Hold aw_valid_o and aw_addr_o stable until aw_ready_i.
  - On the handshake: outstanding +1, next_addr += BURST_LEN*DATA_WIDTH/8 (mod 2^BUS_ADDR_W), beat_cnt <= 0, go to DATA.
- DATA:
  - w_valid_o = ~fifo_empty_i.
  - fifo_rd_valid_o = w_valid_o & w_ready_i.
  - w_last_o = (beat_cnt == BURST_LEN-1) & w_valid_o.
  - Each beat handshake increments beat_cnt.
  - The last-beat handshake does: burst_left -1, go to IDLE.
  - If that makes burst_left 0: armed <= 0, frame_done_o pulses the next cycle, and next_addr is not reused.
- Outstanding counter:
  - +1 on each aw handshake, -1 on each b_valid_i.
  - A simultaneous increment and decrement leaves it unchanged.
  - b_valid_i with outstanding == 0 is ignored; the counter never underflows.
- busy_o = armed | (state != IDLE) | (outstanding != 0).

## Timing
- Reset values:
  - state IDLE.
  - aw_valid_o, w_valid_o, w_last_o, fifo_rd_valid_o, frame_done_o, busy_o all 0.
  - aw_addr_o 0, outstanding 0, armed 0, beat_cnt 0, burst_left 0.
  - b_ready_o is 1.
  - aw_len_o is BURST_LEN-1.
- Reset assertion mid-burst aborts immediately. Partial bursts are neither completed nor replayed.
- Start condition true in cycle n: aw_valid_o is high in cycle n+1.
- aw handshake in cycle m: the first w beat can be valid in cycle m+1.
- Beats run back-to-back, one per cycle, while w_ready_i=1.
- Last beat in cycle k: state is IDLE in k+1, and the next aw_valid_o can be high no earlier than k+2 (one bubble).
- w_valid_o, w_last_o and fifo_rd_valid_o are combinational from state, fifo_empty_i and w_ready_i. aw_* are registered.
- fifo_counter_i is sampled only in IDLE, so FIFO writes during a burst never affect the burst in flight.

## Test plan
- Reset, then frame_start_i with base 0x1000, burst_num 2, BURST_LEN 16, DATA_WIDTH 32, FIFO preloaded with 40 words, ready always 1 -> aw at 0x1000 and 0x1040, 32 pops, w_last_o on beats 15 and 31, frame_done_o pulses once, busy_o drops after 2 b_valid_i.
- FIFO at 15 words, armed -> no aw_valid_o. Add a 16th word -> aw_valid_o exactly 1 cycle later.
- aw_ready_i held low 5 cycles -> aw_addr_o and aw_valid_o stable throughout. w_ready_i toggling -> beats and pops occur only on handshake cycles, with the data order preserved.
- b_valid_i withheld, MAX_OUTSTANDING 2, burst_num 3 -> only 2 bursts issued. One b_valid_i -> the third burst starts. b_valid_i simultaneous with an aw handshake -> outstanding unchanged.
- Base 0xFFFF_FFC0, burst_num 2 -> second address 0x0000_0000 (wrap).
- Edge cases:
  - cfg_burst_num_i 0 -> start ignored, busy_o stays 0.
  - frame_start_i during DATA -> ignored.
  - rst_n low mid-burst -> all outputs at reset values in the same cycle.
